node_seq: RTL and testbench
===========================

# node_seq

Sequencer that drives one `node` datapath. It accepts a 64-sample input frame over a valid/ready stream and holds a 64-entry coefficient table. Once a frame is complete it clears the node accumulator and streams index, coefficient and sample pairs into the node. After a fixed drain latency it captures `node_out` and returns it on a valid/ready result port. It sits between the frame source (upstream) and `node`, and is the initiator of the `start`/`reset_acc`/`cnt_val`/`coef`/`data_in` interface.

## Interface
- DATA_W, 16, sample and coefficient width
- DEPTH, 64, samples per frame and coefficient entries
- CNT_W, 7, width of `cnt_val`
- OUT_W, 3, width of `node_out` and `res_data`
- NODE_LAT, 2, cycles between the last `start` and sampling of `node_out`

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample valid
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  DATA_W  sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  6  coefficient index
- coef_wdata  in  DATA_W  coefficient value
- start  out  1  to node: operand pair valid
- reset_acc  out  1  to node: clear accumulator
- cnt_val  out  CNT_W  to node: operand index
- coef  out  DATA_W  to node: coefficient
- data_in  out  DATA_W  to node: sample
- node_out  in  OUT_W  from node: result
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid && res_ready
- res_data  out  OUT_W  captured node_out
- busy  out  1  high in every state except LOAD with 0 samples held
- coef_err  out  1  see Configuration

## Operation
- FSM states: LOAD → CLEAR → RUN → WAIT → RESULT → LOAD.
- LOAD: `in_ready`=1. Each accepted sample is written to `buf[wr_cnt]` and `wr_cnt` increments. When the DEPTH-th sample is accepted, the FSM goes to CLEAR and `wr_cnt` returns to 0.
- CLEAR: one cycle. `reset_acc`=1 and `in_ready`=0.
- RUN: exactly DEPTH cycles, index k=0..DEPTH-1. Each cycle drives `start`=1, `cnt_val`=k (zero-extended), `coef`=coef_mem[k] and `data_in`=buf[k].
- WAIT: NODE_LAT cycles with `start`=0. On the clock edge that ends the last WAIT cycle, `node_out` is registered into `res_data`.
- RESULT: `res_valid`=1, and `res_data` is held stable until the `res_valid && res_ready` handshake. After the handshake the FSM returns to LOAD. `res_ready` may be held low indefinitely; nothing is lost.
- Outside their active states, `start`, `reset_acc`, `cnt_val`, `coef` and `data_in` are 0.
- Coefficient table: `coef_we` writes `coef_mem[coef_addr]` at the clock edge, in any state (subject to Configuration).
  - A write and a RUN read of the same index in the same cycle returns the old value.
- Reset value of every output is 0, except `in_ready`, which becomes 1 in the first cycle after `rst` deasserts.
  - `coef_mem`, `buf`, the counters and `res_data` clear to 0.
  - `rst` asserted mid-frame or mid-RUN abandons the frame. There is no partial result, and LOAD restarts at index 0.
- A sample presented with `in_valid` while `in_ready`=0 is not accepted; it must be held by the source.

## Timing
- The first sample is accepted at cycle t. With `in_valid` continuously high, the DEPTH-th sample is accepted at t+DEPTH-1.
- CLEAR at t+DEPTH.
- RUN from t+DEPTH+1 to t+2·DEPTH, with `cnt_val`=0 at t+DEPTH+1.
- WAIT from t+2·DEPTH+1 to t+2·DEPTH+NODE_LAT.
- `res_valid` rises at t+2·DEPTH+NODE_LAT+1. With defaults this is t+131.
- The earliest next-frame acceptance is the cycle after the result handshake.

## Configuration
- Macro `NODE_SEQ_COEF_LOCK_EN`.
- Defined: `coef_we` while `busy`=1 is ignored and `coef_mem` is unchanged. `coef_err` pulses high for one cycle, the cycle after the rejected write.
- Undefined: writes apply in any state, so a RUN in progress may use a mix of old and new coefficients. `coef_err` is tied to 0.

## Test plan
- Reset: hold `rst`=1 for 3 cycles mid-RUN → all outputs 0 during reset, `in_ready`=1 on the first cycle after release, `cnt_val`=0.
- Full frame: write coef[k]=k+1, stream samples k=0..63 with no gaps, model `node` as a behavioural MAC → one `reset_acc` pulse at t+64, 64 consecutive `start` cycles with `cnt_val` 0..63 and correctly paired coef/data, `res_valid` at t+131 with the expected `res_data`.
- Input gaps: toggle `in_valid` every other cycle → exactly 64 samples captured in order, CLEAR the cycle after the 64th acceptance.
- Backpressure: hold `res_ready`=0 for 20 cycles → `res_valid` and `res_data` stable, `in_ready`=0 throughout. After the handshake, `in_ready`=1 the next cycle.
- Coefficient write during RUN at coef_addr=10 (value 0x00FF):
  - With `NODE_SEQ_COEF_LOCK_EN` → table unchanged, `coef_err` 1-cycle pulse.
  - Without it → a later frame uses 0x00FF at `cnt_val`=10.
- Back-to-back frames: two frames with the result accepted immediately → the second CLEAR occurs 1+64 cycles after the first handshake, and the second result is independent of the first.

Source files
------------

// File: rtl/node_seq.sv
// node_seq: buffers a DEPTH-sample frame, then streams index/coef/sample pairs into a node MAC and returns its result.
// Latency: res_valid rises DEPTH+NODE_LAT+2 cycles after the last sample is accepted. Build option: NODE_SEQ_COEF_LOCK_EN.
// Backpressure: in_ready is low outside LOAD; the result is held in RESULT until res_ready.
module node_seq #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 64,
    parameter int CNT_W    = 7,
    parameter int OUT_W    = 3,
    parameter int NODE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [5:0]        coef_addr,
    input  logic [DATA_W-1:0] coef_wdata,
    output logic              start,
    output logic              reset_acc,
    output logic [CNT_W-1:0]  cnt_val,
    output logic [DATA_W-1:0] coef,
    output logic [DATA_W-1:0] data_in,
    input  logic [OUT_W-1:0]  node_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic              busy,
    output logic              coef_err
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WAIT_W = $clog2(NODE_LAT + 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLEAR,
        S_RUN,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [OUT_W-1:0]    res_data_q, res_data_d;
    logic                coef_err_q, coef_err_d;
    logic [DATA_W-1:0]   buf_q [DEPTH];
    logic [DATA_W-1:0]   coef_mem_q [DEPTH];
    logic                buf_we;
    logic                coef_wr_ok;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wait_cnt_d = wait_cnt_q;
        res_data_d = res_data_q;
        buf_we     = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    buf_we = 1'b1;
                    if (wr_cnt_q == IDX_W'(DEPTH - 1)) begin
                        wr_cnt_d = '0;
                        state_d  = S_CLEAR;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                rd_cnt_d = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (rd_cnt_q == IDX_W'(DEPTH - 1)) begin
                    rd_cnt_d   = '0;
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // node_out is sampled on the edge that closes the last wait cycle
                if (wait_cnt_q == WAIT_W'(NODE_LAT - 1)) begin
                    res_data_d = node_out;
                    wait_cnt_d = '0;
                    state_d    = S_RESULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_comb begin
`ifdef NODE_SEQ_COEF_LOCK_EN
        coef_wr_ok = coef_we && !busy;
        coef_err_d = coef_we && busy;
`else
        coef_wr_ok = coef_we;
        coef_err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wait_cnt_q <= '0;
            res_data_q <= '0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i]      <= '0;
                coef_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            res_data_q <= res_data_d;
            coef_err_q <= coef_err_d;
            if (buf_we) begin
                buf_q[wr_cnt_q] <= in_data;
            end
            // RUN reads the table combinationally, so a same-index write is seen next cycle
            if (coef_wr_ok) begin
                coef_mem_q[coef_addr] <= coef_wdata;
            end
        end
    end

    assign in_ready  = (state_q == S_LOAD) && !rst;
    assign start     = (state_q == S_RUN);
    assign reset_acc = (state_q == S_CLEAR);
    assign cnt_val   = start ? CNT_W'(rd_cnt_q) : '0;
    assign coef      = start ? coef_mem_q[rd_cnt_q] : '0;
    assign data_in   = start ? buf_q[rd_cnt_q] : '0;
    assign res_valid = (state_q == S_RESULT);
    assign res_data  = res_data_q;
    assign busy      = !((state_q == S_LOAD) && (wr_cnt_q == '0));
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_node_seq.sv
// Directed bench for node_seq with a behavioural node MAC and pair/result scoreboards.
module tb_node_seq;
    localparam int DATA_W = 16, DEPTH = 64, CNT_W = 7, OUT_W = 3, NODE_LAT = 2;

    typedef struct packed {
        logic [6:0]  k;
        logic [15:0] c;
        logic [15:0] d;
    } pair_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, coef_we, start, reset_acc, res_valid, res_ready, busy, coef_err;
    logic [DATA_W-1:0] in_data, coef_wdata, coef, data_in;
    logic [5:0]        coef_addr;
    logic [CNT_W-1:0]  cnt_val;
    logic [OUT_W-1:0]  node_out, res_data;

    always #5 clk = ~clk;

    node_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .OUT_W(OUT_W), .NODE_LAT(NODE_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .start(start), .reset_acc(reset_acc), .cnt_val(cnt_val), .coef(coef), .data_in(data_in),
        .node_out(node_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .coef_err(coef_err)
    );

    // behavioural node: MAC with a one-cycle output register
    logic [47:0]      acc_q  = '0;
    logic [OUT_W-1:0] nout_q = '0;
    always @(posedge clk) begin
        if (reset_acc) acc_q <= '0;
        else if (start) acc_q <= acc_q + 48'(coef) * 48'(data_in);
        nout_q <= acc_q[OUT_W-1:0];
    end
    assign node_out = nout_q;

    int n_chk = 0, n_pass = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    pair_t          pq[$];
    logic [2:0]     rq[$];
    logic [15:0]    coef_m [64];
    logic [15:0]    samp_m [64];
    logic [63:0]    sum;
    pair_t          p, e;
    int n_acc = 0, first_acc_cyc = 0, last_acc_cyc = 0, clear_cyc = 0, rv_cyc = 0, hs_cyc = 0;
    int start_cnt = 0, n_clear = 0, n_res = 0;
    bit pending = 0, exp_err = 0, prev_rv = 0, busy_exp;

    // scoreboard monitor: predicts on acceptance, compares when the DUT produces
    always @(negedge clk) begin
        if (rst) begin
            pq.delete(); rq.delete();
            n_acc = 0; pending = 0; exp_err = 0; start_cnt = 0; prev_rv = 0;
            for (int i = 0; i < 64; i++) coef_m[i] = '0;
        end else begin
            busy_exp = (n_acc > 0) || pending;
            chk("busy", 64'(busy), 64'(busy_exp));
            chk("coef_err", 64'(coef_err), 64'(exp_err));
            exp_err = 0;
            if (coef_we) begin
`ifdef NODE_SEQ_COEF_LOCK_EN
                if (busy_exp) exp_err = 1;
                else coef_m[coef_addr] = coef_wdata;
`else
                coef_m[coef_addr] = coef_wdata;
`endif
            end
            if (reset_acc) begin
                chk("clear_after_last_sample", 64'(cyc), 64'(last_acc_cyc + 1));
                chk("pairs_queued", 64'(pq.size()), 64'd64);
                clear_cyc = cyc; start_cnt = 0; n_clear++;
            end
            if (start) begin
                if (start_cnt == 0) chk("run_first_cycle", 64'(cyc), 64'(clear_cyc + 1));
                chk("pair_available", 64'(pq.size() != 0), 64'd1);
                if (pq.size() != 0) begin
                    e = pq.pop_front();
                    chk("cnt_val", 64'(cnt_val), 64'(e.k));
                    chk("coef", 64'(coef), 64'(e.c));
                    chk("data_in", 64'(data_in), 64'(e.d));
                end
                start_cnt++;
            end
            if (res_valid && !prev_rv) begin
                chk("res_valid_timing", 64'(cyc), 64'(clear_cyc + DEPTH + NODE_LAT + 1));
                chk("run_length", 64'(start_cnt), 64'd64);
                rv_cyc = cyc;
            end
            if (res_valid && res_ready) begin
                chk("result_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) chk("res_data", 64'(res_data), 64'(rq.pop_front()));
                hs_cyc = cyc; pending = 0; n_res++;
            end
            if (in_valid && in_ready) begin
                if (n_acc == 0) first_acc_cyc = cyc;
                samp_m[n_acc] = in_data;
                last_acc_cyc = cyc;
                n_acc++;
                if (n_acc == 64) begin
                    sum = '0;
                    for (int k = 0; k < 64; k++) begin
                        p.k = 7'(k); p.c = coef_m[k]; p.d = samp_m[k];
                        pq.push_back(p);
                        sum = sum + 64'(coef_m[k]) * 64'(samp_m[k]);
                    end
                    rq.push_back(sum[2:0]);
                    n_acc = 0; pending = 1;
                end
            end
            prev_rv = res_valid;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input bit gaps);
        int n;
        step();
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin in_valid = 1'b0; step(); end
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 600) begin @(negedge clk); n++; end
            chk("in_ready_wait", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idx(input int idx);
        int n = 0;
        @(negedge clk);
        while (!(start && cnt_val == 7'(idx)) && n < 600) begin @(negedge clk); n++; end
        chk("wait_idx", 64'({start, cnt_val}), 64'({1'b1, 7'(idx)}));
    endtask

    task automatic wait_res(input int prev);
        int n = 0;
        while (n_res == prev && n < 600) begin @(negedge clk); n++; end
        chk("result_seen", 64'(n_res), 64'(prev + 1));
    endtask

    function automatic logic [63:0] outs_vec();
        return 64'({start, reset_acc, cnt_val, coef, data_in, res_valid, res_data, in_ready, busy, coef_err});
    endfunction

    initial begin
        logic [OUT_W-1:0] held;
        int nr, n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0;
        coef_wdata = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs_vec(), 64'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        chk("cnt_val_after_reset", 64'(cnt_val), 64'd0);

        // full frame, coef[k] = k+1, no gaps
        step();
        for (int k = 0; k < 64; k++) begin
            coef_we = 1'b1; coef_addr = 6'(k); coef_wdata = 16'(k + 1); step();
        end
        coef_we = 1'b0; res_ready = 1'b1;
        nr = n_res; send_frame(1'b0); wait_res(nr);
        chk("f1_clear_at_t64", 64'(clear_cyc), 64'(first_acc_cyc + 64));
        chk("f1_res_valid_at_t131", 64'(rv_cyc), 64'(first_acc_cyc + 131));
        chk("f1_clear_count", 64'(n_clear), 64'd1);

        // gapped input with result backpressure
        step(); res_ready = 1'b0;
        send_frame(1'b1);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 600) begin @(negedge clk); n++; end
        chk("f2_res_valid", 64'(res_valid), 64'd1);
        held = res_data;
        repeat (20) begin
            @(negedge clk);
            chk("backpressure_hold", 64'({res_valid, in_ready, res_data}), 64'({1'b1, 1'b0, held}));
        end
        step(); res_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
        chk("f2_result_count", 64'(n_res), 64'd2);

        // coefficient write at index 10 during RUN, then a back-to-back frame
        send_frame(1'b0);
        wait_idx(19);
        step(); coef_we = 1'b1; coef_addr = 6'd10; coef_wdata = 16'h00FF;
        step(); coef_we = 1'b0;
        send_frame(1'b0);
        repeat (3) @(negedge clk);
        chk("f3_result_count", 64'(n_res), 64'd3);
        chk("b2b_clear_after_handshake", 64'(clear_cyc), 64'(hs_cyc + 65));
        wait_idx(10);
`ifdef NODE_SEQ_COEF_LOCK_EN
        chk("f4_coef10_locked", 64'(coef), 64'd11);
`else
        chk("f4_coef10_updated", 64'(coef), 64'h00FF);
`endif
        wait_res(3);

        // reset in the middle of RUN abandons the frame
        send_frame(1'b0);
        wait_idx(20);
        step(); rst = 1'b1;
        step();
        @(negedge clk);
        chk("mid_run_reset_outputs", outs_vec(), 64'd0);
        step(); step(); rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_mid_reset", 64'(in_ready), 64'd1);
        chk("cnt_val_after_mid_reset", 64'(cnt_val), 64'd0);
        chk("res_valid_after_mid_reset", 64'(res_valid), 64'd0);

        // fresh frame after reset: cleared table, index restarts at 0
        nr = n_res; send_frame(1'b0); wait_res(nr);
        chk("pairs_drained", 64'(pq.size()), 64'd0);
        chk("results_drained", 64'(rq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
